// File: rtl/invaders_formation.sv
// invaders_formation: ROWS x COLS invader grid that marches, descends, takes
// bullet hits, keeps score and decides win/lose. Optional macro: SPEEDUP_EN.
module invaders_formation #(
    parameter int ROWS     = 4,
    parameter int COLS     = 5,
    parameter int X_W      = 5,
    parameter int Y_W      = 4,
    parameter int X_MAX    = 31,
    parameter int Y_LOSE   = 15,
    parameter int STEP_DIV = 18000000
) (
    input  logic                 i_clk_36MHz,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_bullet_valid,
    input  logic [X_W-1:0]       i_bullet_x,
    input  logic [Y_W-1:0]       i_bullet_y,
    output logic                 o_hit,
    output logic [ROWS*COLS-1:0] o_invaders_array,
    output logic [X_W-1:0]       o_formation_x,
    output logic [Y_W-1:0]       o_invaders_line,
    output logic [7:0]           o_score,
    output logic [1:0]           o_state
);
    localparam int N     = ROWS * COLS;
    localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WIN  = 2'b10,
        S_LOSE = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N-1:0]     r_array;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_line;
    logic             r_dir_right;
    logic [7:0]       r_score;
    logic             r_hit;
    logic [CNT_W-1:0] r_tick;

    logic [COLS-1:0]  w_col_alive;
    logic [ROWS-1:0]  w_row_alive;
    logic [X_W-1:0]   w_lc;
    logic [X_W-1:0]   w_rc;
    logic [Y_W:0]     w_rmax;
    logic             w_hit;
    logic [N-1:0]     w_hit_mask;
    logic             w_win;
    logic             w_lose;
    logic             w_run;
    logic             w_start;
    logic [CNT_W-1:0] w_last;
    logic             w_step;

    // Which columns and rows still hold at least one live invader.
    always_comb begin
        w_col_alive = '0;
        w_row_alive = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_array[r*COLS+c]) begin
                    w_col_alive[c] = 1'b1;
                    w_row_alive[r] = 1'b1;
                end
            end
        end
    end

    // Live extent: leftmost/rightmost column, bottom row.
    always_comb begin
        w_lc   = '0;
        w_rc   = '0;
        w_rmax = '0;
        for (int c = COLS - 1; c >= 0; c--)
            if (w_col_alive[c]) w_lc = X_W'(c);
        for (int c = 0; c < COLS; c++)
            if (w_col_alive[c]) w_rc = X_W'(c);
        for (int r = 0; r < ROWS; r++)
            if (w_row_alive[r]) w_rmax = (Y_W+1)'(r);
    end

    // Bullet match against the registered position; first match wins.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (!w_hit && i_bullet_valid && r_array[r*COLS+c] &&
                    i_bullet_x == r_x + X_W'(c) &&
                    i_bullet_y == r_line + Y_W'(r)) begin
                    w_hit               = 1'b1;
                    w_hit_mask[r*COLS+c] = 1'b1;
                end
            end
        end
    end

`ifdef SPEEDUP_EN
    localparam int PC_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'((STEP_DIV >> 1) - 1);
    localparam logic [CNT_W-1:0] LAST_QTR  = CNT_W'((STEP_DIV >> 2) - 1);
    logic [PC_W-1:0] w_alive_cnt;

    // Shorter march period as the formation thins out.
    always_comb begin
        w_alive_cnt = '0;
        for (int i = 0; i < N; i++)
            w_alive_cnt = w_alive_cnt + PC_W'(r_array[i]);
        if (w_alive_cnt > PC_W'(N / 2))
            w_last = LAST_FULL;
        else if (w_alive_cnt > PC_W'(N / 4))
            w_last = LAST_HALF;
        else
            w_last = LAST_QTR;
    end
`else
    assign w_last = LAST_FULL;
`endif

    assign w_win   = (r_array == '0);
    assign w_lose  = ({1'b0, r_line} + w_rmax) >= (Y_W+1)'(Y_LOSE);
    assign w_run   = (r_state == S_PLAY) && !w_win && !w_lose;
    assign w_start = (r_state != S_PLAY) && i_start;
    assign w_step  = (r_tick == w_last);

    // Game state register.
    always_ff @(posedge i_clk_36MHz or negedge i_reset_n) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next state: start from any idle/end state, end checks while playing.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_PLAY: begin
                if (w_win)       w_state_nxt = S_WIN;
                else if (w_lose) w_state_nxt = S_LOSE;
            end
            default: begin
                if (i_start) w_state_nxt = S_PLAY;
            end
        endcase
    end

    // Formation datapath: restart, hits, score, tick counter and march.
    always_ff @(posedge i_clk_36MHz or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_array     <= '1;
            r_x         <= '0;
            r_line      <= '0;
            r_dir_right <= 1'b1;
            r_score     <= '0;
            r_hit       <= 1'b0;
            r_tick      <= '0;
        end else if (w_start) begin
            r_array     <= '1;
            r_x         <= '0;
            r_line      <= '0;
            r_dir_right <= 1'b1;
            r_score     <= '0;
            r_hit       <= 1'b0;
            r_tick      <= '0;
        end else if (w_run) begin
            r_hit <= w_hit;
            if (w_hit) begin
                r_array <= r_array & ~w_hit_mask;
                if (r_score != 8'hFF) r_score <= r_score + 8'd1;
            end
            if (r_tick > w_last)
                r_tick <= w_last;
            else if (w_step)
                r_tick <= '0;
            else
                r_tick <= r_tick + CNT_W'(1);
            if (w_step) begin
                if (r_dir_right) begin
                    if (({1'b0, r_x} + {1'b0, w_rc}) < (X_W+1)'(X_MAX)) begin
                        r_x <= r_x + X_W'(1);
                    end else begin
                        r_line      <= r_line + Y_W'(1);
                        r_dir_right <= 1'b0;
                    end
                end else begin
                    if (({1'b0, r_x} + {1'b0, w_lc}) != '0) begin
                        r_x <= r_x - X_W'(1);
                    end else begin
                        r_line      <= r_line + Y_W'(1);
                        r_dir_right <= 1'b1;
                    end
                end
            end
        end else begin
            r_hit <= 1'b0;
        end
    end

    assign o_hit            = r_hit;
    assign o_invaders_array = r_array;
    assign o_formation_x    = r_x;
    assign o_invaders_line  = r_line;
    assign o_score          = r_score;
    assign o_state          = r_state;

endmodule

// File: tb/tb_invaders_formation.sv
// tb_invaders_formation: scoreboard bench for the invader formation engine
// with a 4-cycle march period.
`timescale 1ns/1ps
module tb_invaders_formation;
    localparam int STEP_DIV = 4;
    localparam int SEL_ST = 0, SEL_ARR = 1, SEL_X = 2;
    localparam int SEL_LN = 3, SEL_SC = 4, SEL_HIT = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        bv    = 1'b0;
    logic [4:0]  bx    = '0;
    logic [3:0]  by    = '0;
    logic        hit;
    logic [19:0] arr;
    logic [4:0]  fx;
    logic [3:0]  line;
    logic [7:0]  score;
    logic [1:0]  state;

    always #5 clk = ~clk;

    invaders_formation #(
        .ROWS(4), .COLS(5), .X_W(5), .Y_W(4),
        .X_MAX(31), .Y_LOSE(15), .STEP_DIV(STEP_DIV)
    ) dut (
        .i_clk_36MHz     (clk),
        .i_reset_n       (rst_n),
        .i_start         (start),
        .i_bullet_valid  (bv),
        .i_bullet_x      (bx),
        .i_bullet_y      (by),
        .o_hit           (hit),
        .o_invaders_array(arr),
        .o_formation_x   (fx),
        .o_invaders_line (line),
        .o_score         (score),
        .o_state         (state)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    task automatic expect_out(string tag, int sel, logic [31:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic expect_all(string p, logic [1:0] st, logic [19:0] a,
                              logic [4:0] x, logic [3:0] ln,
                              logic [7:0] sc, logic h);
        expect_out({p, ".state"}, SEL_ST, 32'(st));
        expect_out({p, ".array"}, SEL_ARR, 32'(a));
        expect_out({p, ".x"}, SEL_X, 32'(x));
        expect_out({p, ".line"}, SEL_LN, 32'(ln));
        expect_out({p, ".score"}, SEL_SC, 32'(sc));
        expect_out({p, ".hit"}, SEL_HIT, 32'(h));
    endtask

    function automatic logic [31:0] obs_of(int sel);
        case (sel)
            SEL_ST:  return 32'(state);
            SEL_ARR: return 32'(arr);
            SEL_X:   return 32'(fx);
            SEL_LN:  return 32'(line);
            SEL_SC:  return 32'(score);
            default: return 32'(hit);
        endcase
    endfunction

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, obs_of(e.sel), e.exp);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic restart();
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        start = 1'b1;
        expect_out("restart.state", SEL_ST, 32'd1);
        expect_out("restart.array", SEL_ARR, 32'hFFFFF);
        cyc(1);
        start = 1'b0;
        drain();
    endtask

    task automatic kill(int first, int last);
        for (int i = first; i <= last; i++) begin
            bv = 1'b1;
            bx = fx + 5'(i % 5);
            by = line + 4'(i / 5);
            cyc(1);
        end
        bv = 1'b0;
    endtask

    task automatic measure(output int per);
        logic [4:0] x0;
        int n;
        x0 = fx;
        n  = 0;
        while (fx == x0 && n < 20) begin
            cyc(1);
            n++;
        end
        x0 = fx;
        n  = 0;
        do begin
            cyc(1);
            n++;
        end while (fx == x0 && n < 20);
        per = n;
    endtask

    initial begin
        logic [19:0] m;
        int t;
        int per;
        int exp_p10;
        int exp_p15;

        // Reset values, and a bullet in IDLE is ignored.
        cyc(2);
        expect_all("rst", 2'd0, 20'hFFFFF, 5'd0, 4'd0, 8'd0, 1'b0);
        drain();
        rst_n = 1'b1;
        bv = 1'b1; bx = 5'd0; by = 4'd0;
        expect_all("idle_shot", 2'd0, 20'hFFFFF, 5'd0, 4'd0, 8'd0, 1'b0);
        cyc(1);
        bv = 1'b0;
        drain();

        // Start, then asynchronous reset mid-play.
        start = 1'b1;
        expect_all("start", 2'd1, 20'hFFFFF, 5'd0, 4'd0, 8'd0, 1'b0);
        cyc(1);
        start = 1'b0;
        drain();
        cyc(6);
        #2 rst_n = 1'b0;
        #1 expect_all("async", 2'd0, 20'hFFFFF, 5'd0, 4'd0, 8'd0, 1'b0);
        drain();
        cyc(1);

        // March right to the edge, descend, then march left.
        restart();
        cyc(4);
        expect_out("m1.x", SEL_X, 32'd1);
        drain();
        cyc(4 * 26);
        expect_out("m27.x", SEL_X, 32'd27);
        expect_out("m27.line", SEL_LN, 32'd0);
        drain();
        cyc(4);
        expect_out("desc.x", SEL_X, 32'd27);
        expect_out("desc.line", SEL_LN, 32'd1);
        drain();
        cyc(4);
        expect_out("left1.x", SEL_X, 32'd26);
        drain();
        cyc(4);
        expect_out("left2.x", SEL_X, 32'd25);
        expect_out("left2.state", SEL_ST, 32'd1);
        drain();

        // Single hit at (2,1), then the same bullet held.
        restart();
        bv = 1'b1; bx = 5'd2; by = 4'd1;
        expect_all("hit", 2'd1, 20'hFFF7F, 5'd0, 4'd0, 8'd1, 1'b1);
        cyc(1);
        drain();
        expect_all("hold", 2'd1, 20'hFFF7F, 5'd0, 4'd0, 8'd1, 1'b0);
        cyc(1);
        bv = 1'b0;
        drain();

        // Column 4 destroyed: right edge moves out to x=28.
        restart();
        m = 20'hFFFFF;
        for (int r = 0; r < 4; r++) begin
            bv = 1'b1; bx = 5'd4; by = 4'(r);
            m[r*5+4] = 1'b0;
            cyc(1);
        end
        bv = 1'b0;
        expect_out("col4.array", SEL_ARR, 32'(m));
        expect_out("col4.score", SEL_SC, 32'd4);
        expect_out("col4.x", SEL_X, 32'd1);
        drain();
        cyc(4 * 27);
        expect_out("col4.edge.x", SEL_X, 32'd28);
        expect_out("col4.edge.line", SEL_LN, 32'd0);
        drain();
        cyc(4);
        expect_out("col4.desc.x", SEL_X, 32'd28);
        expect_out("col4.desc.line", SEL_LN, 32'd1);
        drain();
        cyc(4);
        expect_out("col4.left.x", SEL_X, 32'd27);
        drain();

        // Clear every invader while it marches: WIN, then restart.
        restart();
        for (int i = 0; i < 20; i++) begin
            bv = 1'b1;
            bx = 5'(i / 4 + i % 5);
            by = 4'(i / 5);
            expect_out("clear.hit", SEL_HIT, 32'd1);
            cyc(1);
            drain();
        end
        bv = 1'b0;
        cyc(1);
        expect_all("win", 2'd2, 20'h00000, 5'd5, 4'd0, 8'd20, 1'b0);
        drain();
        cyc(10);
        expect_out("win.hold.x", SEL_X, 32'd5);
        expect_out("win.hold.state", SEL_ST, 32'd2);
        drain();
        start = 1'b1;
        expect_all("replay", 2'd1, 20'hFFFFF, 5'd0, 4'd0, 8'd0, 1'b0);
        cyc(1);
        start = 1'b0;
        drain();

        // Untouched formation reaches the bottom: LOSE at line 12.
        restart();
        t = 1;
        while (state != 2'd3 && t < 2000) begin
            cyc(1);
            t++;
        end
        check("lose.cycle", 32'(t), 32'(4 * 12 * 28 + 2));
        expect_all("lose", 2'd3, 20'hFFFFF, 5'd0, 4'd12, 8'd0, 1'b0);
        drain();
        cyc(8);
        expect_out("lose.hold.x", SEL_X, 32'd0);
        expect_out("lose.hold.line", SEL_LN, 32'd12);
        drain();

        // March period as the formation thins.
`ifdef SPEEDUP_EN
        exp_p10 = STEP_DIV >> 1;
        exp_p15 = STEP_DIV >> 2;
`else
        exp_p10 = STEP_DIV;
        exp_p15 = STEP_DIV;
`endif
        restart();
        kill(0, 9);
        expect_out("k10.score", SEL_SC, 32'd10);
        drain();
        measure(per);
        check("k10.period", 32'(per), 32'(exp_p10));
        kill(10, 14);
        expect_out("k15.score", SEL_SC, 32'd15);
        drain();
        measure(per);
        check("k15.period", 32'(per), 32'(exp_p15));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/invaders_formation.md
Name: invaders_formation

Overview:
Parametrised invader-formation engine: a ROWS x COLS grid of invaders that marches, descends, takes bullet hits, keeps score and decides win/lose. It supersedes the fixed 4x5 invaders/gameplay pair and feeds the sprite drawer (alive mask, position) and the player (hit pulse). It adds an alive-extent-aware march, a score counter and a start/restart FSM.

Parameters:
ROWS, 4, formation rows
COLS, 5, formation columns
X_W, 5, width of column coordinates
Y_W, 4, width of row coordinates
X_MAX, 31, rightmost legal column coordinate
Y_LOSE, 15, row coordinate at which a live invader means defeat
STEP_DIV, 18000000, clock cycles per march step (at least 4)

Ports:
i_clk_36MHz  in  1  system clock
i_reset_n  in  1  reset, asynchronous, active-low
i_start  in  1  start/restart request, level sampled each cycle
i_bullet_valid  in  1  bullet coordinates valid this cycle
i_bullet_x  in  X_W  bullet column
i_bullet_y  in  Y_W  bullet row
o_hit  out  1  one-cycle pulse: an invader was destroyed
o_invaders_array  out  ROWS*COLS  alive mask; bit r*COLS+c = invader (r,c)
o_formation_x  out  X_W  column of grid column 0
o_invaders_line  out  Y_W  row of grid row 0
o_score  out  8  destroyed-invader count, saturating
o_state  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE

Behaviour:
- Reset (i_reset_n low, async): state IDLE; array all ones; formation_x 0; line 0; dir right; score 0; o_hit 0; tick counter 0.
- Geometry: invader (r,c) sits at x = formation_x + c, y = line + r (unsigned, X_W/Y_W wide).
- IDLE/WIN/LOSE: outputs hold. i_start=1 → next cycle: array all ones, formation_x 0, line 0, dir right, score 0, tick 0, state PLAY. In PLAY, i_start is ignored.
- Tick counter (PLAY only): counts 0..period-1. period = STEP_DIV. Wrap = march step.
- March step: Lc/Rc = lowest/highest column index holding any live invader (OR over rows).
  - dir right, formation_x+Rc < X_MAX → formation_x+1.
  - dir right, formation_x+Rc = X_MAX → line+1, dir left, x unchanged.
  - dir left, formation_x+Lc > 0 → formation_x−1.
  - dir left, formation_x+Lc = 0 → line+1, dir right.
- Hit detect (PLAY, combinational on registered position): i_bullet_valid and an alive invader at (i_bullet_x, i_bullet_y). Next edge: bit cleared, o_hit=1 for exactly one cycle, score+1 (holds at 255). At most one invader per cycle.
- Hit and march step in the same cycle: hit evaluated against the pre-step position; both take effect on the same edge.
- Hit outside PLAY: ignored, o_hit stays 0.
- End detection (PLAY, on registered values, one cycle after the causing update):
  - array all zero → WIN.
  - else line + (highest row holding a live invader) ≥ Y_LOSE → LOSE.
  - Both true → WIN.
  - The tick counter freezes on leaving PLAY.
- Reset mid-game: immediate return to reset values. No pending o_hit survives.
- Widths: position arithmetic never wraps; edge rules keep formation_x + Rc ≤ X_MAX. Descend stops mattering once LOSE is entered.

Optional Feature:
SPEEDUP_EN defined:
- period = STEP_DIV while alive count > ROWS*COLS/2.
- period = STEP_DIV>>1 while alive count ≤ ROWS*COLS/2 and > ROWS*COLS/4.
- period = STEP_DIV>>2 while alive count ≤ ROWS*COLS/4.
- Integer division throughout. The new period applies from the next counter restart; the counter is clamped to the new period−1 if it is already beyond it.

SPEEDUP_EN undefined: period is always STEP_DIV, and no population-count logic is present.

Test Plan:
- Bench parameters: STEP_DIV=4, defaults otherwise.
1. Reset low mid-PLAY → all outputs at reset values immediately. Release + i_start pulse → o_state=01 the next cycle, array=20'hFFFFF.
2. PLAY, no bullets → formation_x increments every 4 cycles to 27 (Rc=4). Next step: line 1, x stays 27. Following steps: x decrements.
3. Bullet at (2,1) at reset position → bit 7 cleared, o_hit high for 1 cycle, score=1. Same bullet held → no second hit.
4. Kill column 4 entirely → right edge reached at formation_x=28 instead of 27.
5. Clear all 20 invaders → o_state=10, score=20, position frozen. i_start → PLAY with full array, score 0.
6. No hits, let the formation march → LOSE when line+3 reaches 15 (line=12). With SPEEDUP_EN and 10 killed → step every 2 cycles. With 15 killed → every cycle.
